// File: rtl/shifter_operand_pipe_if.sv
// Request/result bundle for shifter_operand_pipe: operand request in, shifted operand out.
// Latency: none (wiring only).
// Backpressure: in_valid/in_ready on the request side, out_valid/out_ready on the result side.
interface shifter_operand_pipe_if #(
    parameter int TAG_W     = 4,
    parameter int OUT_DEPTH = 2
);
    localparam int CNT_W = $clog2(OUT_DEPTH) + 1;

    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [TAG_W-1:0] in_tag;
    logic [31:0]      in_a;
    logic [31:0]      in_instr;
    logic [7:0]       in_rs;
    logic             in_c;
    logic             out_valid;
    logic             out_ready;
    logic [TAG_W-1:0] out_tag;
    logic [31:0]      out_result;
    logic             out_c;
    logic             out_undef;
    logic [CNT_W-1:0] fifo_count;

    // Requester / consumer side (decode stage feeding in, execute stage draining out).
    modport master (
        output flush, in_valid, in_tag, in_a, in_instr, in_rs, in_c, out_ready,
        input  in_ready, out_valid, out_tag, out_result, out_c, out_undef, fifo_count
    );

    // Shifter unit side.
    modport slave (
        input  flush, in_valid, in_tag, in_a, in_instr, in_rs, in_c, out_ready,
        output in_ready, out_valid, out_tag, out_result, out_c, out_undef, fifo_count
    );
endinterface

// File: rtl/shifter_operand_pipe.sv
// ARM shifter operand / addressing offset unit: S1 register, 1-cycle barrel shifter, output FIFO.
// Latency: accept at edge N -> out_valid after edge N+1 when the FIFO is empty.
// Backpressure: in_ready drops when S1 is held by a full, non-popping FIFO; SHIFTER_REG_SHIFT_EN enables register-specified shifts.
module shifter_operand_pipe #(
    parameter int TAG_W     = 4,
    parameter int OUT_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    shifter_operand_pipe_if.slave bus
);
    localparam int PTR_W = $clog2(OUT_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(OUT_DEPTH);

    typedef enum logic [1:0] {
        SH_LSL = 2'd0,
        SH_LSR = 2'd1,
        SH_ASR = 2'd2,
        SH_ROR = 2'd3
    } shift_e;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [31:0]      a;
        logic [31:0]      instr;
        logic [7:0]       rs;
        logic             c;
    } s1_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [31:0]      result;
        logic             c;
        logic             undef;
    } res_t;

    // Barrel shift by n in 1..32. Returns {carry_out, result}.
    // Left shifts widen by one bit so the last bit out lands in bit 32; right shifts
    // append a guard bit below bit 0 that catches the last bit out. ROR fills from a itself.
    function automatic logic [32:0] barrel(input shift_e ty, input logic [5:0] n, input logic [31:0] a);
        logic [32:0] lsh;
        logic [32:0] rsh;
        logic [31:0] hi;
        case (ty)
            SH_LSR:  hi = '0;
            SH_ASR:  hi = {32{a[31]}};
            default: hi = a;
        endcase
        lsh = {1'b0, a} << n;
        rsh = 33'({hi, a, 1'b0} >> n);
        if (ty == SH_LSL) begin
            barrel = lsh;
        end else begin
            barrel = {rsh[0], rsh[32:1]};
        end
    endfunction

    // Immediate-amount shift with the zero-amount encodings (LSR/ASR #32, RRX).
    function automatic logic [32:0] imm_shift(input shift_e ty, input logic [4:0] amt,
                                              input logic [31:0] a, input logic c);
        if (amt != 5'd0) begin
            imm_shift = barrel(ty, {1'b0, amt}, a);
        end else begin
            case (ty)
                SH_LSL:  imm_shift = {c, a};
                SH_ROR:  imm_shift = {a[0], c, a[31:1]};
                default: imm_shift = barrel(ty, 6'd32, a);
            endcase
        end
    endfunction

`ifdef SHIFTER_REG_SHIFT_EN
    // Register-amount shift: amount 0 is a pass-through, large amounts saturate.
    function automatic logic [32:0] reg_shift(input shift_e ty, input logic [7:0] amt,
                                              input logic [31:0] a, input logic c);
        logic [5:0] n;
        n = (amt > 8'd32) ? 6'd32 : amt[5:0];
        if (amt == 8'd0) begin
            reg_shift = {c, a};
        end else begin
            case (ty)
                SH_LSL, SH_LSR: reg_shift = (amt > 8'd32) ? 33'd0 : barrel(ty, n, a);
                SH_ASR:         reg_shift = barrel(ty, n, a);
                // Rotating by a multiple of 32 leaves a unchanged with C=a[31].
                default:        reg_shift = barrel(ty, (amt[4:0] == 5'd0) ? 6'd32 : {1'b0, amt[4:0]}, a);
            endcase
        end
    endfunction
`endif

    s1_t              s1_q;
    logic             s1_valid;
    res_t             fifo_mem [OUT_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;

    logic             pop;
    logic             s1_adv;
    logic             push;
    logic             accept;
    logic             in_ready_int;
    logic             head_valid;
    res_t             head;
    res_t             push_dat;

    logic [31:0]      op_res;
    logic             op_c;
    logic             op_undef;

    assign head_valid   = (count_q != '0);
    assign head         = fifo_mem[rd_ptr];
    assign pop          = head_valid && bus.out_ready;
    // A full FIFO still takes S1 when the head leaves in the same cycle.
    assign s1_adv       = s1_valid && ((count_q < DEPTH_C) || pop);
    assign push         = s1_adv && !bus.flush;
    assign in_ready_int = !bus.flush && (!s1_valid || s1_adv);
    assign accept       = bus.in_valid && in_ready_int;

    assign bus.in_ready   = in_ready_int;
    assign bus.out_valid  = head_valid;
    assign bus.out_tag    = head.tag;
    assign bus.out_result = head.result;
    assign bus.out_c      = head.c;
    assign bus.out_undef  = head.undef;
    assign bus.fifo_count = count_q;

    // Operand-2 decode and shift from the S1 contents.
    always_comb begin
        op_res   = '0;
        op_c     = s1_q.c;
        op_undef = 1'b0;
        case (s1_q.instr[27:25])
            3'b000: begin
                if (s1_q.instr[4]) begin
`ifdef SHIFTER_REG_SHIFT_EN
                    {op_c, op_res} = reg_shift(shift_e'(s1_q.instr[6:5]), s1_q.rs, s1_q.a, s1_q.c);
`else
                    op_undef = 1'b1;
`endif
                end else begin
                    {op_c, op_res} = imm_shift(shift_e'(s1_q.instr[6:5]), s1_q.instr[11:7], s1_q.a, s1_q.c);
                end
            end
            3'b001: begin
                // Rotated 8-bit immediate; a zero rotate keeps the incoming carry.
                if (s1_q.instr[11:8] == 4'd0) begin
                    op_res = {24'd0, s1_q.instr[7:0]};
                end else begin
                    {op_c, op_res} = barrel(SH_ROR, {1'b0, s1_q.instr[11:8], 1'b0}, {24'd0, s1_q.instr[7:0]});
                end
            end
            3'b010: begin
                op_res = {20'd0, s1_q.instr[11:0]};
            end
            3'b011: begin
                // Register offset: all-zero shift field means plain Rm.
                if (s1_q.instr[11:4] == 8'd0) begin
                    op_res = s1_q.a;
                end else begin
                    {op_c, op_res} = imm_shift(shift_e'(s1_q.instr[6:5]), s1_q.instr[11:7], s1_q.a, s1_q.c);
                end
            end
            default: begin
                op_undef = 1'b1;
            end
        endcase
    end

    assign push_dat = '{tag: s1_q.tag, result: op_res, c: op_c, undef: op_undef};

    // S1 capture register: loads on accept, empties when its result moves into the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (bus.flush) begin
            s1_valid <= 1'b0;
        end else if (accept) begin
            s1_valid   <= 1'b1;
            s1_q.tag   <= bus.in_tag;
            s1_q.a     <= bus.in_a;
            s1_q.instr <= bus.in_instr;
            s1_q.rs    <= bus.in_rs;
            s1_q.c     <= bus.in_c;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Output FIFO: in-order ring buffer, flush empties it and wins over a pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            for (int i = 0; i < OUT_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else if (bus.flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= push_dat;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Instruction bits outside the decoded fields are intentionally ignored.
    logic unused_bits;
`ifdef SHIFTER_REG_SHIFT_EN
    assign unused_bits = ^{s1_q.instr[31:28], s1_q.instr[24:12]};
`else
    assign unused_bits = ^{s1_q.instr[31:28], s1_q.instr[24:12], s1_q.rs};
`endif

endmodule

// File: tb/tb_shifter_operand_pipe.sv
// Bench for shifter_operand_pipe: directed operand vectors, backpressure, flush and async reset.
// Outputs are compared every falling edge against a queue model built from the operand rules.
// Honors SHIFTER_REG_SHIFT_EN the same way as the design.
module tb_shifter_operand_pipe;
    localparam int TAG_W     = 4;
    localparam int OUT_DEPTH = 2;

    typedef struct {
        logic [3:0]  tag;
        logic [31:0] a;
        logic [31:0] instr;
        logic [7:0]  rs;
        logic        c;
    } op_t;

    typedef struct {
        logic [3:0]  tag;
        logic [31:0] res;
        logic        c;
        logic        undef;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    shifter_operand_pipe_if #(.TAG_W(TAG_W), .OUT_DEPTH(OUT_DEPTH)) bus ();

    shifter_operand_pipe #(.TAG_W(TAG_W), .OUT_DEPTH(OUT_DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // ---------------- reference model (operand rules in plain arithmetic) ----------------
    function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
        int m;
        m = n % 32;
        if (m == 0) return x;
        return (x >> m) | (x << (32 - m));
    endfunction

    // Ordinary shift by 1..31; returns {carry, result}.
    function automatic logic [32:0] plain_shift(input logic [1:0] ty, input int n, input logic [31:0] a);
        logic [31:0] r;
        case (ty)
            2'd0: return {a[32-n], a << n};
            2'd1: return {a[n-1], a >> n};
            2'd2: return {a[n-1], 32'($signed(a) >>> n)};
            default: begin
                r = ror32(a, n);
                return {r[31], r};
            end
        endcase
    endfunction

    function automatic logic [32:0] shift_imm(input logic [1:0] ty, input int amt, input logic [31:0] a, input logic c);
        if (amt != 0) return plain_shift(ty, amt, a);
        case (ty)
            2'd0: return {c, a};
            2'd1: return {a[31], 32'h0};
            2'd2: return {a[31], {32{a[31]}}};
            default: return {a[0], c, a[31:1]};
        endcase
    endfunction

    function automatic logic [32:0] shift_reg(input logic [1:0] ty, input int amt, input logic [31:0] a, input logic c);
        if (amt == 0) return {c, a};
        case (ty)
            2'd0: begin
                if (amt < 32) return plain_shift(ty, amt, a);
                if (amt == 32) return {a[0], 32'h0};
                return 33'h0;
            end
            2'd1: begin
                if (amt < 32) return plain_shift(ty, amt, a);
                if (amt == 32) return {a[31], 32'h0};
                return 33'h0;
            end
            2'd2: begin
                if (amt < 32) return plain_shift(ty, amt, a);
                return {a[31], {32{a[31]}}};
            end
            default: begin
                if (amt % 32 == 0) return {a[31], a};
                return plain_shift(ty, amt % 32, a);
            end
        endcase
    endfunction

    function automatic exp_t model_of(input op_t op);
        exp_t e;
        logic [2:0] mode;
        int n;
        e.tag   = op.tag;
        e.res   = 32'h0;
        e.c     = op.c;
        e.undef = 1'b0;
        mode    = op.instr[27:25];
        if (mode[2]) begin
            e.undef = 1'b1;
        end else if (mode == 3'b010) begin
            e.res = {20'h0, op.instr[11:0]};
        end else if (mode == 3'b001) begin
            n     = 2 * int'(op.instr[11:8]);
            e.res = ror32({24'h0, op.instr[7:0]}, n);
            if (n != 0) e.c = e.res[31];
        end else if (mode == 3'b011 && op.instr[11:4] == 8'h00) begin
            e.res = op.a;
        end else if (mode == 3'b000 && op.instr[4]) begin
`ifdef SHIFTER_REG_SHIFT_EN
            {e.c, e.res} = shift_reg(op.instr[6:5], int'(op.rs), op.a, op.c);
`else
            e.undef = 1'b1;
`endif
        end else begin
            {e.c, e.res} = shift_imm(op.instr[6:5], int'(op.instr[11:7]), op.a, op.c);
        end
        return e;
    endfunction

    // ---------------- per-cycle compare against the queue model ----------------
    exp_t m_q[$];
    op_t  m_s1;
    logic m_s1_vld = 1'b0;

    always @(negedge clk) begin
        logic exp_vld, room, exp_rdy, adv;
        if (!rst_n) begin
            m_q.delete();
            m_s1_vld = 1'b0;
            chk("reset out_valid", 32'(bus.out_valid), 32'h0);
            chk("reset out_result", bus.out_result, 32'h0);
            chk("reset fifo_count", 32'(bus.fifo_count), 32'h0);
        end else begin
            exp_vld = (m_q.size() != 0);
            room    = (m_q.size() < OUT_DEPTH) || (exp_vld && bus.out_ready);
            exp_rdy = !bus.flush && (!m_s1_vld || room);
            adv     = m_s1_vld && room;
            chk("model in_ready", 32'(bus.in_ready), 32'(exp_rdy));
            chk("model out_valid", 32'(bus.out_valid), 32'(exp_vld));
            chk("model fifo_count", 32'(bus.fifo_count), 32'(m_q.size()));
            if (exp_vld) begin
                chk("model out_tag", 32'(bus.out_tag), 32'(m_q[0].tag));
                chk("model out_result", bus.out_result, m_q[0].res);
                chk("model out_c", 32'(bus.out_c), 32'(m_q[0].c));
                chk("model out_undef", 32'(bus.out_undef), 32'(m_q[0].undef));
            end
            if (bus.flush) begin
                m_q.delete();
                m_s1_vld = 1'b0;
            end else begin
                if (exp_vld && bus.out_ready) void'(m_q.pop_front());
                if (adv) m_q.push_back(model_of(m_s1));
                if (bus.in_valid && exp_rdy) begin
                    m_s1_vld = 1'b1;
                    m_s1     = '{tag: bus.in_tag, a: bus.in_a, instr: bus.in_instr, rs: bus.in_rs, c: bus.in_c};
                end else if (adv) begin
                    m_s1_vld = 1'b0;
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    logic [3:0] next_tag = 4'd1;

    // One operation into an empty pipe with out_ready=1; checks latency and literal results.
    task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] instr,
                          input logic [7:0] rs, input logic c,
                          input logic [31:0] er, input logic ec, input logic eu);
        logic [3:0] t;
        t             = next_tag;
        next_tag      = next_tag + 4'd1;
        bus.in_valid  = 1'b1;
        bus.in_tag    = t;
        bus.in_a      = a;
        bus.in_instr  = instr;
        bus.in_rs     = rs;
        bus.in_c      = c;
        bus.out_ready = 1'b1;
        chk({nm, " in_ready"}, 32'(bus.in_ready), 32'h1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk({nm, " early out_valid"}, 32'(bus.out_valid), 32'h0);
        @(posedge clk); #1;
        chk({nm, " out_valid"}, 32'(bus.out_valid), 32'h1);
        chk({nm, " result"}, bus.out_result, er);
        chk({nm, " carry"}, 32'(bus.out_c), 32'(ec));
        chk({nm, " undef"}, 32'(bus.out_undef), 32'(eu));
        chk({nm, " tag"}, 32'(bus.out_tag), 32'(t));
    endtask

    task automatic drive_req(input logic [3:0] t, input logic [31:0] a, input logic [31:0] instr);
        bus.in_valid = 1'b1;
        bus.in_tag   = t;
        bus.in_a     = a;
        bus.in_instr = instr;
        bus.in_rs    = 8'h00;
        bus.in_c     = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int accepted;
        rst_n         = 1'b0;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_tag    = '0;
        bus.in_a      = '0;
        bus.in_instr  = '0;
        bus.in_rs     = '0;
        bus.in_c      = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        chk("rst out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst out_result", bus.out_result, 32'h0);
        chk("rst out_c", 32'(bus.out_c), 32'h0);
        chk("rst out_tag", 32'(bus.out_tag), 32'h0);
        chk("rst out_undef", 32'(bus.out_undef), 32'h0);
        chk("rst fifo_count", 32'(bus.fifo_count), 32'h0);
        @(posedge clk); @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post-reset in_ready", 32'(bus.in_ready), 32'h1);

        // Operand vectors with hand-computed results.
        run_op("lsl4",      32'hF000_0001, 32'h0000_0200, 8'd0, 1'b0, 32'h0000_0010, 1'b1, 1'b0);
        run_op("imm_rot8",  32'h0000_0000, 32'h0200_04FF, 8'd0, 1'b0, 32'hFF00_0000, 1'b1, 1'b0);
        run_op("imm_rot0",  32'h0000_0000, 32'h0200_00FF, 8'd0, 1'b1, 32'h0000_00FF, 1'b1, 1'b0);
        run_op("asr0",      32'h8000_0000, 32'h0000_0040, 8'd0, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run_op("rrx",       32'h0000_0003, 32'h0000_0060, 8'd0, 1'b1, 32'h8000_0001, 1'b1, 1'b0);
        run_op("lsr0",      32'h8000_0000, 32'h0000_0020, 8'd0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        run_op("lsr1",      32'h0000_0003, 32'h0000_00A0, 8'd0, 1'b0, 32'h0000_0001, 1'b1, 1'b0);
        run_op("asr4",      32'h8000_0010, 32'h0000_0240, 8'd0, 1'b1, 32'hF800_0001, 1'b0, 1'b0);
        run_op("ror8",      32'h1234_5678, 32'h0000_0460, 8'd0, 1'b1, 32'h7812_3456, 1'b0, 1'b0);
        run_op("imm12",     32'hDEAD_BEEF, 32'h0400_0ABC, 8'd0, 1'b0, 32'h0000_0ABC, 1'b0, 1'b0);
        run_op("reg_off",   32'h1234_5678, 32'h0600_0000, 8'd0, 1'b1, 32'h1234_5678, 1'b1, 1'b0);
        run_op("scaled",    32'h4000_0001, 32'h0600_0100, 8'd0, 1'b0, 32'h0000_0004, 1'b1, 1'b0);
        run_op("undef1xx",  32'hFFFF_FFFF, 32'h0800_0000, 8'd0, 1'b1, 32'h0000_0000, 1'b1, 1'b1);
`ifdef SHIFTER_REG_SHIFT_EN
        run_op("rlsr32",    32'h8000_0000, 32'h0000_0030, 8'd32, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        run_op("rlsr33",    32'h8000_0000, 32'h0000_0030, 8'd33, 1'b0, 32'h0000_0000, 1'b0, 1'b0);
        run_op("rlsr0",     32'h8000_0000, 32'h0000_0030, 8'd0,  1'b1, 32'h8000_0000, 1'b1, 1'b0);
        run_op("rror32",    32'h8000_0001, 32'h0000_0070, 8'd32, 1'b0, 32'h8000_0001, 1'b1, 1'b0);
`else
        run_op("rlsr32",    32'h8000_0000, 32'h0000_0030, 8'd32, 1'b0, 32'h0000_0000, 1'b0, 1'b1);
        run_op("rlsr33",    32'h8000_0000, 32'h0000_0030, 8'd33, 1'b0, 32'h0000_0000, 1'b0, 1'b1);
        run_op("rlsr0",     32'h8000_0000, 32'h0000_0030, 8'd0,  1'b1, 32'h0000_0000, 1'b1, 1'b1);
        run_op("rror32",    32'h8000_0001, 32'h0000_0070, 8'd32, 1'b0, 32'h0000_0000, 1'b0, 1'b1);
`endif
        @(posedge clk); #1;

        // Backpressure: five back-to-back requests into a stalled consumer.
        bus.out_ready = 1'b0;
        accepted      = 0;
        for (int t = 1; t <= 5; t++) begin
            drive_req(4'(t), 32'(t), 32'h0000_0200);
            if (bus.in_ready) accepted++;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        chk("bp accepted", 32'(accepted), 32'd3);
        chk("bp in_ready stalled", 32'(bus.in_ready), 32'h0);
        chk("bp fifo_count", 32'(bus.fifo_count), 32'd2);
        bus.out_ready = 1'b1;
        #1;
        chk("bp in_ready on pop", 32'(bus.in_ready), 32'h1);
        for (int t = 1; t <= 3; t++) begin
            chk("bp pop valid", 32'(bus.out_valid), 32'h1);
            chk("bp pop tag", 32'(bus.out_tag), 32'(t));
            @(posedge clk); #1;
        end
        chk("bp drained", 32'(bus.out_valid), 32'h0);

        // Flush with three operations in flight.
        bus.out_ready = 1'b0;
        for (int t = 6; t <= 8; t++) begin
            drive_req(4'(t), 32'h0000_0100, 32'h0000_0200);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        chk("flush pre count", 32'(bus.fifo_count), 32'd2);
        bus.flush     = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        chk("flush in_ready", 32'(bus.in_ready), 32'h0);
        @(posedge clk); #1;
        bus.flush = 1'b0;
        chk("flush fifo_count", 32'(bus.fifo_count), 32'h0);
        chk("flush out_valid", 32'(bus.out_valid), 32'h0);
        @(posedge clk); #1;
        chk("flush s1 cleared", 32'(bus.out_valid), 32'h0);

        // Asynchronous reset in the middle of traffic.
        bus.out_ready = 1'b0;
        drive_req(4'd9, 32'h0, 32'h0200_04FF);
        @(posedge clk); #1;
        drive_req(4'd10, 32'h0, 32'h0200_04FF);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("arst pre valid", 32'(bus.out_valid), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst out_valid", 32'(bus.out_valid), 32'h0);
        chk("arst out_result", bus.out_result, 32'h0);
        chk("arst out_c", 32'(bus.out_c), 32'h0);
        chk("arst out_tag", 32'(bus.out_tag), 32'h0);
        chk("arst out_undef", 32'(bus.out_undef), 32'h0);
        chk("arst fifo_count", 32'(bus.fifo_count), 32'h0);
        @(posedge clk); @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("arst in_ready", 32'(bus.in_ready), 32'h1);
        run_op("after_rst", 32'hF000_0001, 32'h0000_0200, 8'd0, 1'b0, 32'h0000_0010, 1'b1, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
